// File: rtl/hpdmc_burst_seq.sv
// DDR DQ/DQS data-path burst sequencer: write beats at WL, read capture at CL, read turnaround gap.
// Optional build macro HPDMC_RDLAT_TRIM_EN adds rd_lat_adj to stretch the read latency by 0..3 cycles.
module hpdmc_burst_seq #(
  parameter int BURST_LEN = 4,
  parameter int CL        = 3,
  parameter int WL        = 1,
  parameter int TURN      = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cmd_valid,
  input  logic        cmd_we,
  output logic        cmd_ready,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_mask,
  output logic        wr_ready,
  output logic [63:0] rd_data,
  output logic        rd_valid,
  output logic        direction,
  output logic [7:0]  mo,
  output logic [63:0] do_data,
  input  logic [63:0] di,
`ifdef HPDMC_RDLAT_TRIM_EN
  input  logic [1:0]  rd_lat_adj,
`endif
  output logic        busy
);

`ifdef HPDMC_RDLAT_TRIM_EN
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLAT,
    S_WDATA,
    S_RLAT,
    S_RDATA,
    S_TURN
  } state_t;

  // Latency states load (latency - 2): the accept cycle and the exit cycle both count toward it.
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] C_BL   = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] C_WL   = CNT_W'((WL > 1) ? (WL - 2) : 0);
  localparam logic [CNT_W-1:0] C_TURN = CNT_W'((TURN > 0) ? (TURN - 1) : 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_rd_data;
  logic             r_rd_valid;

  logic [4:0]       w_rd_lat;
  logic [CNT_W-1:0] w_rd_load;
  logic             w_wdata;

`ifdef HPDMC_RDLAT_TRIM_EN
  assign w_rd_lat = 5'(CL) + {3'b000, rd_lat_adj};
`else
  assign w_rd_lat = 5'(CL);
`endif
  assign w_rd_load = CNT_W'(w_rd_lat - 5'd2);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= C_ZERO;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 64'd0;
    end else begin
      r_rd_valid <= (r_state == S_RDATA);
      if (r_state == S_RDATA) begin
        r_rd_data <= di;
      end
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_we) begin
              if (WL == 1) begin
                r_state <= S_WDATA;
                r_cnt   <= C_BL;
              end else begin
                r_state <= S_WLAT;
                r_cnt   <= C_WL;
              end
            end else begin
              if (w_rd_lat == 5'd1) begin
                r_state <= S_RDATA;
                r_cnt   <= C_BL;
              end else begin
                r_state <= S_RLAT;
                r_cnt   <= w_rd_load;
              end
            end
          end
        end
        S_WLAT: begin
          if (r_cnt == C_ZERO) begin
            r_state <= S_WDATA;
            r_cnt   <= C_BL;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_WDATA: begin
          if (r_cnt == C_ZERO) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_RLAT: begin
          if (r_cnt == C_ZERO) begin
            r_state <= S_RDATA;
            r_cnt   <= C_BL;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_RDATA: begin
          if (r_cnt == C_ZERO) begin
            if (TURN == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_TURN;
              r_cnt   <= C_TURN;
            end
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_TURN: begin
          if (r_cnt == C_ZERO) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= C_ZERO;
        end
      endcase
    end
  end

  // Write beats are passed straight through; the I/O block registers them.
  assign w_wdata   = (r_state == S_WDATA);
  assign direction = w_wdata;
  assign wr_ready  = w_wdata;
  assign do_data   = w_wdata ? wr_data : 64'd0;
  assign mo        = w_wdata ? wr_mask : 8'hFF;

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;

endmodule
